mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between the instruction-fetch requester and the load/store (data) requester of the MIPS core.
- Arbitrates requests, sequences memory read/write strobes and waits out the memory read latency.
- Returns read data to the winning requester with a one-cycle valid pulse.
- Sits between the core's fetch/MEM stages and the memory block.

---
 rtl/mem_port_arbiter.sv | 99 +++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store requesters.
// One access in flight; data has priority, bounded by a starvation counter for fetch.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  lat_cnt;
  logic [3:0]  starve_cnt;
  logic        own_i;
  logic        we_q;
  logic        any_req;
  logic        grant_i;
  logic [31:0] win_addr;

  assign any_req  = i_req | d_req;
  assign grant_i  = i_req & (~d_req | (starve_cnt == 4'(STARVE_MAX)));
  assign win_addr = grant_i ? i_addr : d_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: state_nxt = we_q ? RESP : WAIT;
      WAIT:  if (lat_cnt == 4'd1) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt    <= '0;
      starve_cnt <= '0;
      own_i      <= 1'b0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: if (any_req) begin
          own_i     <= grant_i;
          we_q      <= grant_i ? 1'b0 : d_we;
          mem_addr  <= {win_addr[31:2], 2'b00};
          mem_wdata <= grant_i ? '0 : d_wdata;
          // Count data wins only while fetch is waiting; saturate at the limit.
          if (grant_i || !i_req)
            starve_cnt <= '0;
          else if (starve_cnt != 4'(STARVE_MAX))
            starve_cnt <= starve_cnt + 4'd1;
        end
        ISSUE: lat_cnt <= 4'(MEM_LATENCY);
        WAIT: begin
          if (lat_cnt == 4'd1) begin
            if (own_i) i_rdata <= mem_rdata;
            else       d_rdata <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_read  = (state == ISSUE) & ~we_q;
  assign mem_write = (state == ISSUE) &  we_q;
  assign i_valid   = (state == RESP)  &  own_i;
  assign d_valid   = (state == RESP)  & ~own_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single accesses plus sequences
// for reset, simultaneous requests, starvation and reset during the wait phase.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with MEM_LATENCY=1
  logic        rst_n;
  logic        i_req, i_valid, d_req, d_we, d_valid, mem_write, mem_read;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  // DUT with MEM_LATENCY=3
  logic        rst_n3;
  logic        i_req3, i_valid3, d_req3, d_we3, d_valid3, mem_write3, mem_read3;
  logic [31:0] i_addr3, i_rdata3, d_addr3, d_wdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  logic [31:0] mem  [16] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'h0, 32'h0, 32'hEEEEEEEE, 32'h0, 32'h0, 32'h0,
                             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] mem3 [16] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'h0, 32'h0, 32'hEEEEEEEE, 32'h0, 32'h0, 32'h0,
                             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

  assign mem_rdata  = mem[mem_addr[5:2]];
  assign mem_rdata3 = mem3[mem_addr3[5:2]];
  always @(posedge clk) if (mem_write)  mem[mem_addr[5:2]]   <= mem_wdata;
  always @(posedge clk) if (mem_write3) mem3[mem_addr3[5:2]] <= mem_wdata3;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst_n(rst_n3),
    .i_req(i_req3), .i_addr(i_addr3), .i_rdata(i_rdata3), .i_valid(i_valid3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_rdata(d_rdata3), .d_valid(d_valid3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_write(mem_write3),
    .mem_read(mem_read3), .mem_rdata(mem_rdata3)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int viol  = 0;

  always @(negedge clk) begin
    if ((i_valid && d_valid) || (mem_read && mem_write) ||
        (i_valid3 && d_valid3) || (mem_read3 && mem_write3))
      viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_access(input bit sel3, input bit is_i, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic [31:0] rd,
                            output logic [31:0] iss_addr, output logic [31:0] iss_wdata,
                            output logic iss_rd, output logic iss_wr);
    bit done;
    done = 1'b0; lat = 0; rd = '0; iss_addr = '0; iss_wdata = '0; iss_rd = 1'b0; iss_wr = 1'b0;
    @(posedge clk); #1;
    if (sel3) begin
      if (is_i) begin i_req3 = 1'b1; i_addr3 = addr; end
      else begin d_req3 = 1'b1; d_we3 = we; d_addr3 = addr; d_wdata3 = wdata; end
    end else begin
      if (is_i) begin i_req = 1'b1; i_addr = addr; end
      else begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    end
    @(posedge clk);
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        iss_addr  = sel3 ? mem_addr3  : mem_addr;
        iss_wdata = sel3 ? mem_wdata3 : mem_wdata;
        iss_rd    = sel3 ? mem_read3  : mem_read;
        iss_wr    = sel3 ? mem_write3 : mem_write;
      end
      if (is_i ? (sel3 ? i_valid3 : i_valid) : (sel3 ? d_valid3 : d_valid)) begin
        lat  = c;
        rd   = is_i ? (sel3 ? i_rdata3 : i_rdata) : (sel3 ? d_rdata3 : d_rdata);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; i_req3 = 1'b0; d_req3 = 1'b0;
  endtask

  typedef struct {
    bit          is_i;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          lat, d_cyc, i_cyc, n, quiet;
    logic [31:0] rd, ia, iw, d_val, i_val;
    logic        ir, iwr;
    bit          d_seen, i_seen, d_drop;
    bit          seq[10];

    //          is_i we  addr          wdata         lat exp_rd        exp_maddr
    vecs[0] = '{1'b0, 1'b1, 32'h00000008, 32'hAAAAAAAA, 2, 32'hEEEEEEEE, 32'h00000008};
    vecs[1] = '{1'b0, 1'b0, 32'h00000008, 32'h00000000, 3, 32'hAAAAAAAA, 32'h00000008};
    vecs[2] = '{1'b1, 1'b0, 32'h00000004, 32'h00000000, 3, 32'hBBBBBBBB, 32'h00000004};
    vecs[3] = '{1'b0, 1'b0, 32'h00000013, 32'h00000000, 3, 32'hEEEEEEEE, 32'h00000010};
    vecs[4] = '{1'b0, 1'b1, 32'h0000001F, 32'h12345678, 2, 32'hEEEEEEEE, 32'h0000001C};
    vecs[5] = '{1'b1, 1'b0, 32'h0000001E, 32'h00000000, 3, 32'h12345678, 32'h0000001C};
    vecs[6] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 3, 32'hAAAAAAAA, 32'h00000000};
    vecs[7] = '{1'b1, 1'b0, 32'h00000008, 32'h00000000, 3, 32'hAAAAAAAA, 32'h00000008};

    rst_n = 1'b0; rst_n3 = 1'b0;
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = '0;
    i_req3 = 1'b0; i_addr3 = '0; d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = '0; d_wdata3 = '0;

    // Reset held with both requests pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_ctl", {28'h0, mem_read, mem_write, i_valid, d_valid}, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);

    // Release: data wins first, then the waiting fetch
    @(posedge clk); #1;
    rst_n = 1'b1; rst_n3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_grant_read", {31'h0, mem_read}, 32'h1);
    chk("first_grant_addr", mem_addr, 32'h10);
    d_seen = 0; i_seen = 0; d_drop = 0; d_cyc = 0; i_cyc = 0; d_val = '0; i_val = '0;
    for (int c = 2; c <= 40 && !(d_seen && i_seen); c++) begin
      @(posedge clk); #1;
      if (d_drop) begin d_req = 1'b0; d_drop = 0; end
      @(negedge clk);
      if (d_valid && !d_seen) begin d_seen = 1; d_cyc = c; d_val = d_rdata; d_drop = 1; end
      if (i_valid && !i_seen) begin i_seen = 1; i_cyc = c; i_val = i_rdata; end
    end
    @(posedge clk); #1;
    d_req = 1'b0; i_req = 1'b0;
    chk("simul_d_cycle", d_cyc, 3);
    chk("simul_d_data", d_val, 32'hEEEEEEEE);
    chk("simul_i_cycle", i_cyc, 7);
    chk("simul_i_data", i_val, 32'hAAAAAAAA);

    for (int k = 0; k < 8; k++) begin
      run_access(1'b0, vecs[k].is_i, vecs[k].we, vecs[k].addr, vecs[k].wdata, lat, rd, ia, iw, ir, iwr);
      chk($sformatf("v%0d_latency", k), lat, vecs[k].exp_lat);
      chk($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rd);
      chk($sformatf("v%0d_mem_addr", k), ia, vecs[k].exp_maddr);
      chk($sformatf("v%0d_strobes", k), {30'h0, ir, iwr}, {30'h0, !vecs[k].we, vecs[k].we});
      if (vecs[k].we) chk($sformatf("v%0d_mem_wdata", k), iw, vecs[k].wdata);
    end

    // Starvation: both requesters held high continuously
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; i_req = 1'b1; i_addr = 32'h0;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk);
      if (d_valid)      begin seq[n] = 1'b0; n++; end
      else if (i_valid) begin seq[n] = 1'b1; n++; end
    end
    @(posedge clk); #1;
    d_req = 1'b0; i_req = 1'b0;
    chk("starve_count", n, 10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("starve_grant%0d", k), {31'h0, seq[k]}, {31'h0, (k % 5) == 4});

    // Latency 3 fetch
    run_access(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, lat, rd, ia, iw, ir, iwr);
    chk("l3_fetch_latency", lat, 5);
    chk("l3_fetch_data", rd, 32'hBBBBBBBB);
    chk("l3_fetch_read", {31'h0, ir}, 32'h1);

    // Reset during the wait phase abandons the access
    @(posedge clk); #1;
    d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h10;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("l3_wait_no_strobe", {30'h0, mem_read3, mem_write3}, 32'h0);
    #1 rst_n3 = 1'b0; d_req3 = 1'b0;
    #1;
    chk("rstwait_mem_addr", mem_addr3, 32'h0);
    chk("rstwait_ctl", {28'h0, mem_read3, mem_write3, i_valid3, d_valid3}, 32'h0);
    chk("rstwait_d_rdata", d_rdata3, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n3 = 1'b1;
    quiet = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_valid3 || i_valid3 || mem_read3 || mem_write3) quiet++;
    end
    chk("rstwait_no_activity", quiet, 0);
    run_access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, lat, rd, ia, iw, ir, iwr);
    chk("rstwait_next_latency", lat, 5);
    chk("rstwait_next_data", rd, 32'hEEEEEEEE);

    chk("exclusive_pulses", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
